cnn_frame_sequencer: RTL and testbench

//   Frame-level controller for the MNIST CNN pipeline: LineBuffer -> Conv -> ReLU -> MaxPool -> Dense.
//   - Accepts one frame request at a time.
//   - Gates the 784-pixel input stream and enables/clears the conv/pool datapath.
//   - Counts pooled outputs, then sequences the FC layer.
//   - Holds the predicted class until the host acknowledges it.
//   - Watchdog flags a stalled pipeline.

---
 rtl/cnn_frame_sequencer_if.sv | 33 +++
 rtl/cnn_frame_sequencer.sv | 115 +++++++++++
 tb/tb_cnn_frame_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_frame_sequencer_if.sv
// Host/datapath handshake bundle for the CNN frame sequencer.
// slave = sequencer side, master = host/datapath side.
interface cnn_frame_sequencer_if #(
   parameter int CLASS_W = 4
);
   logic               frame_req;
   logic               frame_ack;
   logic               pix_valid_in;
   logic               pix_ready;
   logic               pipe_en;
   logic               pipe_clr;
   logic               pool_valid;
   logic               fc_start;
   logic               fc_done;
   logic [CLASS_W-1:0] pred_in;
   logic               busy;
   logic               result_valid;
   logic [CLASS_W-1:0] result_class;
   logic               result_ack;
   logic               error;

   modport slave (
      input  frame_req, pix_valid_in, pool_valid, fc_done, pred_in, result_ack,
      output frame_ack, pix_ready, pipe_en, pipe_clr, fc_start, busy,
             result_valid, result_class, error
   );

   modport master (
      output frame_req, pix_valid_in, pool_valid, fc_done, pred_in, result_ack,
      input  frame_ack, pix_ready, pipe_en, pipe_clr, fc_start, busy,
             result_valid, result_class, error
   );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for the MNIST CNN pipeline: gates pixels, tracks pooled
// outputs, runs the dense layer, holds the prediction and watches for stalls.
module cnn_frame_sequencer #(
   parameter int IMG_SIZE    = 28,
   parameter int POOL_OUTS   = 169,
   parameter int TIMEOUT_CYC = 4096,
   parameter int CLASS_W     = 4
) (
   input logic                  clk,
   input logic                  rst,
   cnn_frame_sequencer_if.slave bus
);
   localparam int PIX_TOTAL = IMG_SIZE * IMG_SIZE;
   localparam int PIX_W     = $clog2(PIX_TOTAL + 1);
   localparam int POOL_W    = $clog2(POOL_OUTS + 1);
   localparam int WDOG_W    = $clog2(TIMEOUT_CYC);

   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_TOTAL - 1);
   localparam logic [POOL_W-1:0] POOL_FULL = POOL_W'(POOL_OUTS);
   localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_FC, S_RESULT, S_ERROR
   } state_t;

   state_t              state, state_nxt;
   logic [PIX_W-1:0]    pix_cnt;
   logic [POOL_W-1:0]   pool_cnt;
   logic [WDOG_W-1:0]   wdog;
   logic [CLASS_W-1:0]  cls;
   logic                frame_ack, pipe_en, pipe_clr, fc_start, busy;
   logic                result_valid, error;
   logic                accept, pool_cnt_en, wdog_run;

   assign accept      = bus.pix_valid_in && (state == S_LOAD);
   assign pool_cnt_en = bus.pool_valid && (state == S_LOAD || state == S_DRAIN)
                        && (pool_cnt != POOL_FULL);
   assign wdog_run    = (state == S_DRAIN) || (state == S_FC);

   // The DRAIN exit looks at the registered pool count, so a frame whose last
   // pooled output lands on the final pixel still spends one cycle in DRAIN.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.frame_req) state_nxt = S_CLEAR;
         S_CLEAR:  state_nxt = S_LOAD;
         S_LOAD:   if (accept && pix_cnt == PIX_LAST) state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (pool_cnt == POOL_FULL)                    state_nxt = S_FC;
            else if (!bus.pool_valid && wdog == WDOG_MAX) state_nxt = S_ERROR;
         end
         S_FC: begin
            if (bus.fc_done)            state_nxt = S_RESULT;
            else if (wdog == WDOG_MAX)  state_nxt = S_ERROR;
         end
         S_RESULT: if (bus.result_ack) state_nxt = S_IDLE;
         S_ERROR:  if (bus.frame_req)  state_nxt = S_CLEAR;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         pix_cnt      <= '0;
         pool_cnt     <= '0;
         wdog         <= '0;
         cls          <= '0;
         frame_ack    <= 1'b0;
         pipe_en      <= 1'b0;
         pipe_clr     <= 1'b0;
         fc_start     <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         error        <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == S_CLEAR) begin
            pix_cnt  <= '0;
            pool_cnt <= '0;
         end else begin
            if (accept)      pix_cnt  <= pix_cnt + 1'b1;
            if (pool_cnt_en) pool_cnt <= pool_cnt + 1'b1;
         end

         if (state_nxt != state || (state == S_DRAIN && bus.pool_valid))
            wdog <= '0;
         else if (wdog_run)
            wdog <= wdog + 1'b1;

         if (state == S_FC && bus.fc_done) cls <= bus.pred_in;

         frame_ack    <= (state_nxt == S_CLEAR);
         pipe_clr     <= (state_nxt == S_CLEAR);
         pipe_en      <= (state_nxt == S_LOAD) || (state_nxt == S_DRAIN);
         fc_start     <= (state_nxt == S_FC);
         busy         <= (state_nxt == S_CLEAR) || (state_nxt == S_LOAD) ||
                         (state_nxt == S_DRAIN) || (state_nxt == S_FC);
         result_valid <= (state_nxt == S_RESULT);
         error        <= (state_nxt == S_ERROR);
      end
   end

   assign bus.pix_ready    = (state == S_LOAD);
   assign bus.frame_ack    = frame_ack;
   assign bus.pipe_en      = pipe_en;
   assign bus.pipe_clr     = pipe_clr;
   assign bus.fc_start     = fc_start;
   assign bus.busy         = busy;
   assign bus.result_valid = result_valid;
   assign bus.result_class = cls;
   assign bus.error        = error;
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: a vector table walks two full frames,
// then hand sequences cover gapped input, watchdog, mid-frame reset and recovery.
module tb_cnn_frame_sequencer;
   localparam int TIMEOUT = 4096;

   // control bits: frame_ack,pix_ready,pipe_en,pipe_clr,fc_start,busy,result_valid,error
   localparam logic [7:0] E_IDLE  = 8'b0000_0000;
   localparam logic [7:0] E_CLEAR = 8'b1001_0100;
   localparam logic [7:0] E_LOAD  = 8'b0110_0100;
   localparam logic [7:0] E_DRAIN = 8'b0010_0100;
   localparam logic [7:0] E_FC    = 8'b0000_1100;
   localparam logic [7:0] E_RES   = 8'b0000_0010;
   localparam logic [7:0] E_ERR   = 8'b0000_0001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   acc_cnt = 0;

   cnn_frame_sequencer_if #(.CLASS_W(4)) bus ();

   cnn_frame_sequencer #(
      .IMG_SIZE(28), .POOL_OUTS(169), .TIMEOUT_CYC(TIMEOUT), .CLASS_W(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && bus.pix_valid_in && bus.pix_ready) acc_cnt <= acc_cnt + 1;

   typedef struct {
      string      name;
      logic       req, pix, pool, done, ack;
      logic [3:0] pred;
      int         reps;
      logic [7:0] ctl;
      logic [3:0] cls;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t v(string name, logic req, logic pix, logic pool, logic done,
                              logic ack, logic [3:0] pred, int reps, logic [7:0] ctl,
                              logic [3:0] cls);
      vec_t r;
      r.name = name; r.req = req; r.pix = pix; r.pool = pool; r.done = done;
      r.ack = ack; r.pred = pred; r.reps = reps; r.ctl = ctl; r.cls = cls;
      return r;
   endfunction

   function automatic logic [11:0] obs();
      return {bus.frame_ack, bus.pix_ready, bus.pipe_en, bus.pipe_clr, bus.fc_start,
              bus.busy, bus.result_valid, bus.error, bus.result_class};
   endfunction

   task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic drive(input logic req, input logic pix, input logic pool,
                        input logic done, input logic ack, input logic [3:0] pred);
      bus.frame_req = req; bus.pix_valid_in = pix; bus.pool_valid = pool;
      bus.fc_done = done; bus.result_ack = ack; bus.pred_in = pred;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      drive(0, 0, 0, 0, 0, 4'd0);

      //             name        req pix pool done ack pred reps ctl      cls
      tbl[0]  = v("idle",        0,  0,  0,   0,   0,  0,   2,   E_IDLE,  0);
      tbl[1]  = v("req",         1,  0,  0,   0,   0,  0,   1,   E_CLEAR, 0);
      tbl[2]  = v("load",        1,  0,  0,   0,   0,  0,   1,   E_LOAD,  0);
      tbl[3]  = v("pix783",      1,  1,  0,   0,   1,  0,   783, E_LOAD,  0);
      tbl[4]  = v("pix784",      1,  1,  0,   0,   0,  0,   1,   E_DRAIN, 0);
      tbl[5]  = v("pool168",     1,  0,  1,   1,   0,  0,   168, E_DRAIN, 0);
      tbl[6]  = v("pool169",     1,  0,  1,   0,   0,  0,   1,   E_DRAIN, 0);
      tbl[7]  = v("to_fc",       1,  0,  0,   0,   0,  0,   1,   E_FC,    0);
      tbl[8]  = v("fc_wait",     1,  0,  0,   0,   0,  0,   5,   E_FC,    0);
      tbl[9]  = v("fc_done7",    0,  0,  0,   1,   0,  7,   1,   E_RES,   7);
      tbl[10] = v("hold20",      1,  0,  1,   0,   0,  3,   20,  E_RES,   7);
      tbl[11] = v("ack_req",     1,  0,  0,   0,   1,  3,   1,   E_IDLE,  7);
      tbl[12] = v("clear2",      1,  0,  0,   0,   1,  3,   1,   E_CLEAR, 7);
      tbl[13] = v("load2",       0,  0,  0,   0,   0,  3,   1,   E_LOAD,  7);
      tbl[14] = v("pix_pool",    0,  1,  1,   0,   0,  3,   169, E_LOAD,  7);
      tbl[15] = v("pix_rest",    0,  1,  1,   0,   0,  3,   615, E_DRAIN, 7);
      tbl[16] = v("drain_full",  0,  0,  0,   0,   0,  3,   1,   E_FC,    7);
      tbl[17] = v("fc_first",    0,  0,  0,   1,   0,  9,   1,   E_RES,   9);
      tbl[18] = v("ack",         0,  0,  0,   0,   1,  2,   1,   E_IDLE,  9);
      tbl[19] = v("ack_idle",    0,  0,  0,   1,   1,  2,   2,   E_IDLE,  9);

      step(3);
      chk("reset", obs(), 12'h000);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].req, tbl[i].pix, tbl[i].pool, tbl[i].done, tbl[i].ack, tbl[i].pred);
         step(tbl[i].reps);
         chk(tbl[i].name, obs(), {tbl[i].ctl, tbl[i].cls});
      end
      drive(0, 0, 0, 0, 0, 4'd0);

      // gapped pixel stream
      bus.frame_req = 1'b1;
      for (k = 0; k < 10; k++) begin
         step(1);
         if (bus.frame_ack) break;
      end
      chk_int("gap_ack_seen", int'(k < 10), 1);
      bus.frame_req = 1'b0;
      step(1);
      acc_cnt = 0;
      for (int p = 0; p < 784; p++) begin
         bus.pix_valid_in = 1'b0;
         step($urandom_range(0, 50));
         bus.pix_valid_in = 1'b1;
         step(1);
      end
      bus.pix_valid_in = 1'b0;
      chk("gap_drain", obs(), {E_DRAIN, 4'd9});
      chk_int("gap_accepts", acc_cnt, 784);
      bus.pix_valid_in = 1'b1;
      step(1);
      bus.pix_valid_in = 1'b0;
      chk_int("drain_no_accept", acc_cnt, 784);

      // watchdog: 100 pooled outputs then silence
      bus.pool_valid = 1'b1;
      step(100);
      bus.pool_valid = 1'b0;
      step(TIMEOUT - 1);
      chk("wdog_before", obs(), {E_DRAIN, 4'd9});
      step(1);
      chk("wdog_error", obs(), {E_ERR, 4'd9});
      step(3);
      chk("error_sticky", obs(), {E_ERR, 4'd9});
      bus.frame_req = 1'b1;
      step(1);
      bus.frame_req = 1'b0;
      chk("error_to_clear", obs(), {E_CLEAR, 4'd9});

      // reset mid-LOAD
      step(1);
      bus.pix_valid_in = 1'b1;
      step(400);
      chk("mid_load", obs(), {E_LOAD, 4'd9});
      rst = 1'b1;
      bus.pix_valid_in = 1'b0;
      step(1);
      chk("mid_rst", obs(), 12'h000);
      rst = 1'b0;

      // clean frame after reset
      bus.frame_req = 1'b1;
      step(1);
      bus.frame_req = 1'b0;
      chk("rf_clear", obs(), {E_CLEAR, 4'd0});
      step(1);
      bus.pix_valid_in = 1'b1;
      step(784);
      bus.pix_valid_in = 1'b0;
      chk("rf_drain", obs(), {E_DRAIN, 4'd0});
      bus.pool_valid = 1'b1;
      step(169);
      bus.pool_valid = 1'b0;
      step(1);
      chk("rf_fc", obs(), {E_FC, 4'd0});
      bus.fc_done = 1'b1;
      bus.pred_in = 4'd5;
      step(1);
      bus.fc_done = 1'b0;
      chk("rf_result", obs(), {E_RES, 4'd5});
      bus.result_ack = 1'b1;
      step(1);
      bus.result_ack = 1'b0;
      chk("rf_idle", obs(), {E_IDLE, 4'd5});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
